apb4_completer_mem: RTL and testbench
=====================================

Name: apb4_completer_mem

Overview:
- APB4 completer (slave) holding a word-addressed register memory.
- Sits on one PSELx leg of the APB4 bridge and answers bridge setup/access phases.
- Supports PSTRB byte-lane writes, a configurable number of wait states, and PSLVERR for out-of-range or misaligned addresses.
- Bench drives it standalone with an APB4 requester BFM; in the system it is instantiated once per PSEL0/PSEL1.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8.
- ADDR_WIDTH, 32, PADDR width.
- MEM_DEPTH, 64, number of DATA_WIDTH-bit words.
- WAIT_STATES, 0, PREADY-low cycles inserted in the access phase (0..15).
- STRB_WIDTH (localparam), DATA_WIDTH/8, PSTRB width.

Ports:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STRB_WIDTH  write byte-lane enables.
- PREADY  out  1  transfer completes in the current cycle.
- PRDATA  out  DATA_WIDTH  read data; valid only when PREADY=1 on a read.
- PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - All memory words become 0; FSM goes to IDLE; wait counter cleared.
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - A reset during an ACCESS phase aborts the transfer with no memory update.
- Address decode (PADDR[ADDR_WIDTH-1] is the bridge's slave-select bit and is ignored here):
  - idx = PADDR[ADDR_WIDTH-2:2].
  - err = (PADDR[1:0]!=0) || (idx >= MEM_DEPTH).
- FSM has two states, IDLE and ACCESS.
  - IDLE: if PSEL=1 and PENABLE=0 (setup phase), go to ACCESS and load cnt=WAIT_STATES.
    - If WAIT_STATES=0, PREADY, PRDATA and PSLVERR are registered at this same edge.
    - PENABLE=1 seen in IDLE without a prior setup is ignored; the FSM stays in IDLE.
  - ACCESS, PSEL=1 and cnt>0: cnt decrements each edge. PREADY is set at the edge where cnt reaches 0, so PREADY is high for exactly one access cycle after WAIT_STATES low cycles.
  - ACCESS, PREADY=1 and PENABLE=1 (completion edge):
    - Write with !err: for each lane i with PSTRB[i]=1, mem[idx][8i+7:8i] <= PWDATA[8i+7:8i]; lanes with PSTRB[i]=0 are unchanged.
    - Then PREADY, PSLVERR and PRDATA go to 0 and the FSM returns to IDLE.
  - ACCESS, PSEL=0 (requester abort): return to IDLE, clear outputs, no write.
- Read response: when PREADY is asserted on a read, PRDATA = err ? 0 : mem[idx]. PSTRB is ignored on reads.
- PSLVERR = err when PREADY is asserted, 0 at all other times. An errored write modifies no memory.
- Latency: a transfer takes 2+WAIT_STATES cycles including the setup cycle.
  - Back-to-back transfers: the next setup cycle directly follows completion. The completer accepts it from IDLE with no dead cycle on its side.
- Address, control and data are sampled in the setup cycle for the decode and the read. PWDATA/PSTRB are sampled at the completion edge. APB4 requires these to be stable from setup to completion, so both points give the same values.
- Read-after-write to the same word in consecutive transfers returns the newly written data.
- PREADY, PRDATA and PSLVERR are all registered outputs.

Test Plan:
- Reset: assert PRESET mid-ACCESS. Require PREADY=0, PRDATA=0, PSLVERR=0 immediately (asynchronous), and a read of idx 5 after release returns 0x00000000.
- Full write then read, WAIT_STATES=0: write PADDR=0x14, PWDATA=0xDEADBEEF, PSTRB=0xF, then read 0x14. Require PREADY high in the access cycle of each transfer and PRDATA=0xDEADBEEF.
- Strobed write: word 0x14 holds 0xDEADBEEF; write PWDATA=0x11223344 with PSTRB=0x5. Require a read to return 0xDE22BE44.
- Wait states, WAIT_STATES=3: read 0x14. Require PREADY low for 3 access cycles, high on the 4th, and 5 cycles total from setup.
- Errors:
  - Read 0x100 (idx 64): require PSLVERR=1, PRDATA=0.
  - Write 0x101: require PSLVERR=1 and memory unchanged.
  - PADDR=0x80000014 (MSB set): must decode as idx 5 with no error.
- Abort: drop PSEL during a wait state of a write. Require the FSM to return to IDLE, PREADY never asserted, and the target word unchanged.

Source files
------------

// File: rtl/apb4_completer_mem.sv
// APB4 completer with a word-addressed register memory.
// Byte-lane writes, fixed wait states, PSLVERR on bad addresses.
module apb4_completer_mem #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int ADDR_WIDTH  = 32,
   parameter  int MEM_DEPTH   = 64,
   parameter  int WAIT_STATES = 0,
   localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [STRB_WIDTH-1:0] PSTRB,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR
);

   localparam int IW = ADDR_WIDTH - 3;
   localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  pready_q, pready_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pslverr_q, pslverr_d;
   logic [MW-1:0]         idx_q, idx_d;
   logic                  err_q, err_d;
   logic                  wr_q, wr_d;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // The MSB is the bridge's slave-select bit, not part of our decode.
   logic          unused_sel;
   logic [IW-1:0] a_word;
   logic [MW-1:0] a_idx;
   logic          a_err;

   assign unused_sel = PADDR[ADDR_WIDTH-1];
   assign a_word     = PADDR[ADDR_WIDTH-2:2];
   assign a_idx      = a_word[MW-1:0];
   assign a_err      = (PADDR[1:0] != 2'b00) || (a_word >= IW'(MEM_DEPTH));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = pready_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      idx_d     = idx_q;
      err_d     = err_q;
      wr_d      = wr_q;
      mem_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ACCESS;
               cnt_d   = CNT_LOAD;
               idx_d   = a_idx;
               err_d   = a_err;
               wr_d    = PWRITE;
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  pslverr_d = a_err;
                  prdata_d  = (PWRITE || a_err) ? '0 : mem_q[a_idx];
               end
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_d   = IDLE;
               cnt_d     = '0;
               pready_d  = 1'b0;
               prdata_d  = '0;
               pslverr_d = 1'b0;
            end else if (pready_q) begin
               if (PENABLE) begin
                  mem_we    = wr_q && !err_q;
                  state_d   = IDLE;
                  pready_d  = 1'b0;
                  prdata_d  = '0;
                  pslverr_d = 1'b0;
               end
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = (wr_q || err_q) ? '0 : mem_q[idx_q];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         wr_q      <= 1'b0;
         for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         wr_q      <= wr_d;
         if (mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
               if (PSTRB[i]) mem_q[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
            end
         end
      end
   end

   assign PREADY  = pready_q;
   assign PRDATA  = prdata_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_completer_mem.sv
// Directed bench for apb4_completer_mem.
// One instance with no wait states, one with three.
module tb_apb4_completer_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        psel0 = 1'b0;
   logic        psel3 = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready0, pslverr0, pready3, pslverr3;
   logic [31:0] prdata0, prdata3;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd;
   logic        se;
   int          cyc, lw, cyc2;

   always #5 clk = ~clk;

   apb4_completer_mem #(.WAIT_STATES(0)) dut0 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
   );

   apb4_completer_mem #(.WAIT_STATES(3)) dut3 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Caller is positioned 1 time unit after a rising edge.
   task automatic xfer(input bit s3, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rdata, output logic slverr,
                       output int cycles, output int lows);
      logic rdy;
      psel0   = !s3;
      psel3   = s3;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      pstrb   = st;
      cycles  = 1;
      lows    = 0;
      step(1);
      penable = 1'b1;
      cycles  = 2;
      rdy = s3 ? pready3 : pready0;
      while (!rdy && cycles < 40) begin
         lows++;
         step(1);
         cycles++;
         rdy = s3 ? pready3 : pready0;
      end
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL timeout addr=%h got pready=%b want 1", a, rdy);
      end
      rdata  = s3 ? prdata3 : prdata0;
      slverr = s3 ? pslverr3 : pslverr0;
      step(1);
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b%b%h %b%b%h want all 0",
                  pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
      end
      step(2);
      rst = 1'b0;
      step(1);
      xfer(0, 1, 32'h14, 32'hDEADBEEF, 4'hF, rd, se, cyc, lw);
      psel0  = 1'b1;
      pwrite = 1'b0;
      paddr  = 32'h14;
      step(1);
      penable = 1'b1;
      checks++;
      if (pready0 !== 1'b1 || prdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL pre_reset_read got %b/%h want 1/deadbeef", pready0, prdata0);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (pready0 !== 1'b0 || prdata0 !== 32'h0 || pslverr0 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got %b/%h/%b want 0/0/0", pready0, prdata0, pslverr0);
      end
      psel0   = 1'b0;
      penable = 1'b0;
      step(1);
      rst = 1'b0;
      step(1);
      xfer(0, 0, 32'h14, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'h0 || se !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem got %h/%b want 0/0", rd, se);
      end
   endtask

   task automatic test_write_read();
      xfer(0, 1, 32'h14, 32'hDEADBEEF, 4'hF, rd, se, cyc, lw);
      checks++;
      if (cyc !== 2 || se !== 1'b0) begin
         errors++;
         $display("FAIL write_ws0 got cyc=%0d err=%b want 2/0", cyc, se);
      end
      step(1);
      xfer(0, 0, 32'h14, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (cyc !== 2 || rd !== 32'hDEADBEEF || se !== 1'b0) begin
         errors++;
         $display("FAIL read_ws0 got cyc=%0d %h err=%b want 2 deadbeef 0", cyc, rd, se);
      end
   endtask

   task automatic test_strobe();
      xfer(0, 1, 32'h14, 32'h11223344, 4'h5, rd, se, cyc, lw);
      xfer(0, 0, 32'h14, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'hDE22BE44) begin
         errors++;
         $display("FAIL strobe got %h want de22be44", rd);
      end
   endtask

   task automatic test_wait_states();
      xfer(1, 1, 32'h14, 32'hCAFEF00D, 4'hF, rd, se, cyc, lw);
      checks++;
      if (cyc !== 5 || lw !== 3) begin
         errors++;
         $display("FAIL ws3_write got cyc=%0d lows=%0d want 5/3", cyc, lw);
      end
      xfer(1, 0, 32'h14, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (cyc !== 5 || lw !== 3 || rd !== 32'hCAFEF00D || se !== 1'b0) begin
         errors++;
         $display("FAIL ws3_read got cyc=%0d lows=%0d %h err=%b want 5/3 cafef00d 0",
                  cyc, lw, rd, se);
      end
   endtask

   task automatic test_errors();
      xfer(0, 0, 32'h100, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (se !== 1'b1 || rd !== 32'h0) begin
         errors++;
         $display("FAIL err_range_read got err=%b %h want 1/0", se, rd);
      end
      xfer(0, 1, 32'h101, 32'hFFFFFFFF, 4'hF, rd, se, cyc, lw);
      checks++;
      if (se !== 1'b1) begin
         errors++;
         $display("FAIL err_write_101 got err=%b want 1", se);
      end
      xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'h0 || se !== 1'b0) begin
         errors++;
         $display("FAIL err_write_101_mem got %h/%b want 0/0", rd, se);
      end
      xfer(0, 1, 32'h15, 32'h0, 4'hF, rd, se, cyc, lw);
      checks++;
      if (se !== 1'b1) begin
         errors++;
         $display("FAIL err_misalign got err=%b want 1", se);
      end
      xfer(0, 0, 32'h14, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'hDE22BE44) begin
         errors++;
         $display("FAIL err_misalign_mem got %h want de22be44", rd);
      end
      xfer(0, 0, 32'h80000014, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'hDE22BE44 || se !== 1'b0) begin
         errors++;
         $display("FAIL msb_decode got %h/%b want de22be44/0", rd, se);
      end
   endtask

   task automatic test_back_to_back();
      xfer(0, 1, 32'h20, 32'hA5A5A5A5, 4'hF, rd, se, cyc, lw);
      xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, se, cyc2, lw);
      checks++;
      if (cyc !== 2 || cyc2 !== 2 || rd !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL b2b got cyc=%0d/%0d %h want 2/2 a5a5a5a5", cyc, cyc2, rd);
      end
      xfer(0, 1, 32'h80000018, 32'h00000055, 4'hF, rd, se, cyc, lw);
      xfer(0, 0, 32'h18, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'h55 || se !== 1'b0) begin
         errors++;
         $display("FAIL b2b_msb_write got %h/%b want 55/0", rd, se);
      end
   endtask

   task automatic test_abort();
      logic seen;
      step(1);
      psel3   = 1'b1;
      pwrite  = 1'b1;
      paddr   = 32'h14;
      pwdata  = 32'h12345678;
      pstrb   = 4'hF;
      penable = 1'b0;
      step(1);
      penable = 1'b1;
      seen = pready3;
      step(1);
      seen = seen | pready3;
      psel3   = 1'b0;
      penable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1);
         seen = seen | pready3;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_pready got %b want 0", seen);
      end
      xfer(1, 0, 32'h14, 32'h0, 4'h0, rd, se, cyc, lw);
      checks++;
      if (rd !== 32'hCAFEF00D || cyc !== 5) begin
         errors++;
         $display("FAIL abort_mem got %h cyc=%0d want cafef00d 5", rd, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobe();
      test_wait_states();
      test_errors();
      test_back_to_back();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
